arcade_input_ctrl: RTL
======================

# arcade_input_ctrl

Parametrised player-input front end for arcade cores: merges the HPS joystick words and PS/2 keyboard events into per-player direction, button, start and coin signals. It also captures the DIP bytes and the game-variant byte from the ioctl stream, and shapes coin inputs into fixed-width pulses with an enforced gap. It sits between `hps_io` and the core's per-game input-mapping logic, in the `clk_sys` domain.

## Interface
Parameters:
- `PLAYERS`, 2: number of players, 1–4.
- `BUTTONS`, 4: fire buttons per player, 1–8.
- `DIP_BYTES`, 8: DIP bytes captured, 1–8.
- `COIN_PULSE`, 2400000: coin high time and minimum low gap, in `clk_sys` cycles; must be ≥2.
- `AF_DIV`, 800000: autofire half-period, in cycles; must be ≥1.

Ports:
- `clk_sys`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-high.
- `ps2_key`  in  11  [10] toggle strobe, [9] pressed, [7:0] scancode.
- `joy_in`  in  32*PLAYERS  joystick word per player. Player p occupies bits [32p+31:32p].
- `ioctl_wr`  in  1  download write strobe.
- `ioctl_index`  in  8  download index.
- `ioctl_addr`  in  25  download address.
- `ioctl_dout`  in  8  download data.
- `af_mask`  in  BUTTONS  per-button autofire enable; shared by all players.
- `dir`  out  4*PLAYERS  {up,down,left,right} per player.
- `btn`  out  BUTTONS*PLAYERS  fire buttons per player; bit b of player p is at index BUTTONS*p+b.
- `start`  out  PLAYERS  start per player.
- `coin`  out  PLAYERS  shaped coin pulse per player.
- `dip`  out  8*DIP_BYTES  byte k at [8k+7:8k].
- `mod`  out  8  game-variant byte.

Clock and reset are fixed: single clock `clk_sys`; `reset` is synchronous, active-high.

## Operation
- **Joystick layout:** [0] right, [1] left, [2] down, [3] up, [4+b] button b, [4+BUTTONS] start, [5+BUTTONS] coin.
- **Keyboard latches:** one latch per mapped key. An event is recognised when `ps2_key[10]` differs from its registered copy. On an event the matching latch loads `ps2_key[9]`. Unmapped codes are ignored.
- **Keyboard map, player 0:**
  - arrows 75/72/6B/74 → up/down/left/right.
  - 14/11/29/12 → buttons 0–3.
  - 05 and 16 → start.
  - 76 and 2E → coin.
- **Keyboard map, player 1 (only when PLAYERS≥2):**
  - 2D/2B/23/34 → up/down/left/right.
  - 1C/1B/21/1D → buttons 0–3.
  - 06 and 1E → start.
  - 36 → coin.
- **Keyboard limits:** buttons ≥4 and players ≥2 (index) have no keyboard mapping.
- **Merging:** each raw signal is the OR of the joystick bit and the keyboard latch.
- **Coin shaper:** one FSM per player with states IDLE, PULSE, GAP.
  - IDLE: a raw coin rising edge starts PULSE; the counter loads COIN_PULSE−1 and `coin`=1.
  - PULSE: at count 0 → GAP, counter reloads COIN_PULSE−1, `coin`=0.
  - GAP: at count 0 → IDLE, or → PULSE if `pend` is set (clear `pend`).
  - A rising edge seen in PULSE or GAP sets `pend`. Further edges are dropped, so at most one coin is queued.
- **DIP capture:** write byte `ioctl_addr[2:0]` when `ioctl_wr`, `ioctl_index`==254, and `ioctl_addr` < DIP_BYTES. Out-of-range addresses are ignored.
- **Variant capture:** `mod` loads `ioctl_dout` on any `ioctl_wr` with `ioctl_index`==1.

## Timing
- All outputs are registered.
- Joystick change → `dir`/`btn`/`start` visible after 1 edge.
- Keyboard event edge → latch updates on that edge → output visible 1 edge later.
- Coin: raw rising edge at edge n → `coin` high from edge n+2, for exactly COIN_PULSE cycles, then low for at least COIN_PULSE cycles.
- Reset:
  - all latches, outputs, `dip` and `mod` are 0.
  - coin FSMs go to IDLE with `pend` cleared.
  - the strobe copy loads the current `ps2_key[10]`, so no spurious event follows reset.
  - the autofire phase is 0.
- Reset mid-pulse aborts the pulse; `coin` is 0 on the next cycle.
- A raw coin held high across reset release produces no pulse, because edge detection is re-armed from the sampled level.
- Reset coinciding with `ioctl_wr`: reset wins.
- A keyboard event and a joystick change in the same cycle both take effect.

## Configuration
- `INPUT_AUTOFIRE_EN` defined:
  - a free-running counter toggles the phase every AF_DIV cycles.
  - for each button b with `af_mask[b]`=1, `btn` = raw AND phase; other buttons pass through.
  - the phase counter is reset to 0.
- Undefined: `af_mask` is ignored and `btn` equals the raw merged value; no counter is instantiated.

## Test plan
- Joystick pass-through: PLAYERS=2, `joy_in[32+3]`=1 → `dir[7]`=1 one edge later; other `dir` bits 0.
- Keyboard press/release: toggle strobe with {pressed=1, code 14} → `btn[0]`=1 two edges later; toggle with pressed=0 → `btn[0]`=0; an unmapped code 5A leaves every output unchanged.
- Coin queueing: COIN_PULSE=4; two coin-key edges 2 cycles apart → `coin[0]` high 4, low 4, high 4, then idle. A third edge during the second PULSE is honoured; a third edge during the first GAP is dropped.
- DIP/variant capture: index 254, addresses 0..9 with data 0xA0+addr, DIP_BYTES=8 → `dip`=0xA7A6…A0 and addresses 8–9 ignored; index 1 with data 0x03 → `mod`=0x03.
- Reset mid-operation: assert `reset` during PULSE with the coin key held → `coin`=0 next cycle; no pulse after release until the key is released and pressed again.
- Autofire (macro defined): AF_DIV=3, `af_mask`=0001, button 0 held → `btn[0]` toggles every 3 cycles; button 1 held steady.

Source files
------------

// File: rtl/arcade_input_ctrl.sv
// Player-input front end: merges HPS joystick words and PS/2 key latches, shapes coin pulses,
// and captures DIP / variant bytes from ioctl. Optional autofire: define INPUT_AUTOFIRE_EN.
module arcade_input_ctrl #(
  parameter int PLAYERS    = 2,
  parameter int BUTTONS    = 4,
  parameter int DIP_BYTES  = 8,
  parameter int COIN_PULSE = 2400000,
  parameter int AF_DIV     = 800000
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [10:0]                  ps2_key,
  input  logic [32*PLAYERS-1:0]        joy_in,
  input  logic                         ioctl_wr,
  input  logic [7:0]                   ioctl_index,
  input  logic [24:0]                  ioctl_addr,
  input  logic [7:0]                   ioctl_dout,
  input  logic [BUTTONS-1:0]           af_mask,
  output logic [4*PLAYERS-1:0]         dir,
  output logic [BUTTONS*PLAYERS-1:0]   btn,
  output logic [PLAYERS-1:0]           start,
  output logic [PLAYERS-1:0]           coin,
  output logic [8*DIP_BYTES-1:0]       dip,
  output logic [7:0]                   mod
);

  localparam int NP    = (PLAYERS < 2) ? 2 : PLAYERS;
  localparam bit TWO_P = (PLAYERS >= 2);
  localparam int CW    = $clog2(COIN_PULSE);
  localparam logic [CW-1:0] LOAD = CW'(COIN_PULSE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // Keyboard latches
  logic            key_stb;
  logic            key_evt;
  logic            key_dn;
  logic [7:0]      key_code;
  logic [1:0][3:0] kb_dir;
  logic [1:0][3:0] kb_btn;
  logic [1:0][1:0] kb_start;
  logic [1:0]      kb_coin0;
  logic            kb_coin1;

  assign key_evt  = ps2_key[10] ^ key_stb;
  assign key_dn   = ps2_key[9];
  assign key_code = ps2_key[7:0];

  always_ff @(posedge clk_sys) begin
    key_stb <= ps2_key[10];
    if (reset) begin
      kb_dir   <= '0;
      kb_btn   <= '0;
      kb_start <= '0;
      kb_coin0 <= '0;
      kb_coin1 <= 1'b0;
    end else if (key_evt) begin
      case (key_code)
        8'h75: kb_dir[0][3]   <= key_dn;
        8'h72: kb_dir[0][2]   <= key_dn;
        8'h6B: kb_dir[0][1]   <= key_dn;
        8'h74: kb_dir[0][0]   <= key_dn;
        8'h14: kb_btn[0][0]   <= key_dn;
        8'h11: kb_btn[0][1]   <= key_dn;
        8'h29: kb_btn[0][2]   <= key_dn;
        8'h12: kb_btn[0][3]   <= key_dn;
        8'h05: kb_start[0][0] <= key_dn;
        8'h16: kb_start[0][1] <= key_dn;
        8'h76: kb_coin0[0]    <= key_dn;
        8'h2E: kb_coin0[1]    <= key_dn;
        8'h2D: if (TWO_P) kb_dir[1][3]   <= key_dn;
        8'h2B: if (TWO_P) kb_dir[1][2]   <= key_dn;
        8'h23: if (TWO_P) kb_dir[1][1]   <= key_dn;
        8'h34: if (TWO_P) kb_dir[1][0]   <= key_dn;
        8'h1C: if (TWO_P) kb_btn[1][0]   <= key_dn;
        8'h1B: if (TWO_P) kb_btn[1][1]   <= key_dn;
        8'h21: if (TWO_P) kb_btn[1][2]   <= key_dn;
        8'h1D: if (TWO_P) kb_btn[1][3]   <= key_dn;
        8'h06: if (TWO_P) kb_start[1][0] <= key_dn;
        8'h1E: if (TWO_P) kb_start[1][1] <= key_dn;
        8'h36: if (TWO_P) kb_coin1       <= key_dn;
        default: ;
      endcase
    end
  end

  // Raw merged signals; sized to at least two players so keyboard player 1 always has a slot
  logic [NP-1:0][3:0]         raw_dir;
  logic [NP-1:0][BUTTONS-1:0] raw_btn;
  logic [NP-1:0]              raw_start;
  logic [NP-1:0]              raw_coin;

  always_comb begin
    raw_dir   = '0;
    raw_btn   = '0;
    raw_start = '0;
    raw_coin  = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      raw_dir[p] = joy_in[32*p +: 4];
      for (int unsigned b = 0; b < BUTTONS; b++)
        raw_btn[p][b] = joy_in[32*p + 4 + b];
      raw_start[p] = joy_in[32*p + 4 + BUTTONS];
      raw_coin[p]  = joy_in[32*p + 5 + BUTTONS];
    end
    for (int unsigned k = 0; k < 2; k++) begin
      raw_dir[k]   = raw_dir[k] | kb_dir[k];
      raw_start[k] = raw_start[k] | (|kb_start[k]);
      for (int unsigned b = 0; b < BUTTONS && b < 4; b++)
        raw_btn[k][b] = raw_btn[k][b] | kb_btn[k][b[1:0]];
    end
    raw_coin[0] = raw_coin[0] | (|kb_coin0);
    raw_coin[1] = raw_coin[1] | kb_coin1;
  end

  logic [NP-1:0][BUTTONS-1:0] btn_next;

`ifdef INPUT_AUTOFIRE_EN
  localparam int AW = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
  logic [AW-1:0] af_cnt;
  logic          af_phase;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AW'(AF_DIV - 1)) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end

  always_comb begin
    btn_next = '0;
    for (int unsigned p = 0; p < NP; p++)
      btn_next[p] = raw_btn[p] & (~af_mask | {BUTTONS{af_phase}});
  end

  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joy_in};
`else
  assign btn_next = raw_btn;

  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joy_in, af_mask};
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dir   <= '0;
      btn   <= '0;
      start <= '0;
    end else begin
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        dir[4*p +: 4]             <= raw_dir[p];
        btn[BUTTONS*p +: BUTTONS] <= btn_next[p];
        start[p]                  <= raw_start[p];
      end
    end
  end

  // Coin shaper: two-stage raw sampling puts coin high two edges after the raw edge is sampled
  logic [PLAYERS-1:0] raw_q;
  logic [PLAYERS-1:0] raw_q2;
  logic [PLAYERS-1:0] rise;
  logic [PLAYERS-1:0] pend;
  logic [1:0]         cst  [PLAYERS];
  logic [CW-1:0]      ccnt [PLAYERS];

  assign rise = raw_q & ~raw_q2;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Re-arm edge detection from the sampled level so a held coin does not fire on release
      raw_q  <= raw_coin[PLAYERS-1:0];
      raw_q2 <= raw_coin[PLAYERS-1:0];
      pend   <= '0;
      coin   <= '0;
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        cst[p]  <= S_IDLE;
        ccnt[p] <= '0;
      end
    end else begin
      raw_q  <= raw_coin[PLAYERS-1:0];
      raw_q2 <= raw_q;
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        coin[p] <= (cst[p] == S_PULSE);
        case (cst[p])
          S_IDLE: begin
            if (rise[p]) begin
              cst[p]  <= S_PULSE;
              ccnt[p] <= LOAD;
            end
          end
          S_PULSE: begin
            if (rise[p]) pend[p] <= 1'b1;
            if (ccnt[p] == '0) begin
              cst[p]  <= S_GAP;
              ccnt[p] <= LOAD;
            end else begin
              ccnt[p] <= ccnt[p] - 1'b1;
            end
          end
          S_GAP: begin
            if (ccnt[p] == '0) begin
              if (pend[p] || rise[p]) begin
                cst[p]  <= S_PULSE;
                ccnt[p] <= LOAD;
                pend[p] <= 1'b0;
              end else begin
                cst[p] <= S_IDLE;
              end
            end else begin
              ccnt[p] <= ccnt[p] - 1'b1;
              if (rise[p]) pend[p] <= 1'b1;
            end
          end
          default: cst[p] <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dip <= '0;
      mod <= '0;
    end else if (ioctl_wr) begin
      if (ioctl_index == 8'd254) begin
        for (int unsigned k = 0; k < DIP_BYTES; k++)
          if (ioctl_addr == 25'(k)) dip[8*k +: 8] <= ioctl_dout;
      end
      if (ioctl_index == 8'd1) mod <= ioctl_dout;
    end
  end

endmodule
